aes_inv_subbytes: RTL and testbench
===================================

AES_INV_SUBBYTES -- requirements
Module: aes_inv_subbytes

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 4: number of inverse S-box lookups per cycle; legal values 4, 8, 16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: dataIn holds a valid 128-bit state.
REQ-005 SHALL have port in_ready, output, 1: block can accept a state.
REQ-006 SHALL have port dataIn, input, 128: state from the inverse ShiftRows stage; byte i = dataIn[8i+7:8i].
REQ-007 SHALL have port out_valid, output, 1: dataOut holds a completed result.
REQ-008 SHALL have port out_ready, input, 1: downstream (AddRoundKey) accepts dataOut.
REQ-009 SHALL have port dataOut, output, 128: byte i = InvSbox(input byte i), same byte positions.
REQ-010 SHALL have port busy, output, 1: high whenever the block is not in IDLE.

Function
REQ-011 SHALL implement three states: IDLE, SUB, HOLD.
REQ-012 in_ready SHALL be 1 exactly when in IDLE; it is a decode of state with no combinational path from in_valid or out_ready.
REQ-013 Accept SHALL occur on an edge where state is IDLE and in_valid=1; dataIn is captured into the internal state register, the byte counter is cleared, and state becomes SUB.
REQ-014 In IDLE with in_valid=0, state and dataOut SHALL be held.
REQ-015 N = 16/BYTES_PER_CYCLE; the block SHALL stay in SUB for exactly N cycles.
REQ-016 In SUB cycle k (k=0..N-1) it SHALL replace bytes k*B .. k*B+B-1 (B=BYTES_PER_CYCLE) with their FIPS-197 inverse S-box values; all other bytes are held.
REQ-017 On the edge ending SUB cycle N-1, the fully substituted state SHALL be loaded into dataOut, out_valid set to 1, and state set to HOLD.
REQ-018 Latency: accept on edge t implies out_valid=1 from edge t+N (t+4 at default).
REQ-019 In HOLD, out_valid and dataOut SHALL remain stable until an edge with out_ready=1.
REQ-020 On that edge out_valid SHALL clear and state SHALL return to IDLE; the next accept occurs no earlier than the following edge.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 in_valid while not in IDLE SHALL be ignored; the in-flight state is not corrupted.
REQ-023 dataIn changes after accept SHALL NOT affect the result.
REQ-024 The byte counter SHALL be ceil(log2(N))-bit wide (minimum 1 bit), with no wrap beyond N-1.
REQ-025 The inverse S-box SHALL be purely combinational and bit-exact to FIPS-197 for all 256 inputs.
REQ-026 An illegal BYTES_PER_CYCLE value SHALL cause an elaboration-time error.

Reset
REQ-027 While rst_n=0 on an edge: state=IDLE, out_valid=0, dataOut=0, internal state and counter=0, busy=0, and in_ready=1 after that edge.
REQ-028 Reset asserted in SUB or HOLD SHALL abandon the operation; no out_valid pulse for that state.
REQ-029 Reset SHALL take priority over accept and output handshake on the same edge.

Verification
REQ-030 Default B=4; dataIn=128'h0; in_valid pulsed 1 cycle; out_ready=1 -> out_valid rises 4 cycles after accept, dataOut=128'h52525252_52525252_52525252_52525252, then IDLE.
REQ-031 dataIn=all bytes 8'h63 -> dataOut=128'h0; dataIn=all bytes 8'hFF -> all bytes 8'h7D; dataIn bytes 0..15 = 8'h01 -> all bytes 8'h09.
REQ-032 out_ready held 0 for 10 cycles after out_valid -> dataOut and out_valid stable, in_ready=0, in_valid pulses ignored; release -> single transfer, then in_ready=1.
REQ-033 rst_n driven 0 for one edge during SUB cycle 2 -> no out_valid; next accepted state (128'h0) yields the correct all-8'h52 result.
REQ-034 Sweep all 256 byte values through each byte lane with B=4, 8, 16 -> match the reference InvSbox table; latency 4/2/1 cycles respectively.
REQ-035 Back-to-back stream of 100 random states with random out_ready -> each output equals byte-wise InvSbox of its input, in order, none dropped or duplicated.

Source files
------------

// File: rtl/aes_inv_subbytes.sv
// Iterative AES InvSubBytes over a 128-bit state: BYTES_PER_CYCLE inverse S-box
// lookups per cycle, valid/ready on both sides, one state in flight at a time.
module aes_inv_subbytes #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] dataIn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataOut,
    output logic         busy
);
    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // FIPS-197 inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    if (!(BYTES_PER_CYCLE == 4 || BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("aes_inv_subbytes: BYTES_PER_CYCLE must be 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

    state_t         state;
    logic [127:0]   work;
    logic [127:0]   work_next;
    logic [CW-1:0]  cnt;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    always_comb begin
        // NOTE: default to the held state first; unselected bytes pass through and no latch is inferred.
        work_next = work;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            work_next[(int'(cnt) * BYTES_PER_CYCLE + j) * 8 +: 8] =
                inv_sbox(work[(int'(cnt) * BYTES_PER_CYCLE + j) * 8 +: 8]);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            dataOut   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= dataIn;
                        cnt   <= '0;
                        state <= SUB;
                    end
                end
                SUB: begin
                    work <= work_next;
                    if (cnt == LAST) begin
                        dataOut   <= work_next;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// Scoreboard bench for aes_inv_subbytes: three instances (B=4, 8, 16) share clock
// and reset; drivers queue expected results, per-lane monitors pop and compare.
module tb_aes_inv_subbytes;
    localparam int NI = 3;

    typedef struct {
        logic [127:0] data;
        int unsigned  acc;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [NI];
    logic         out_ready [NI];
    logic [127:0] data_in   [NI];
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         busy      [NI];
    logic [127:0] data_out  [NI];

    exp_t         sb [NI][$];
    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   inv_tab [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_lane
        localparam int B = 4 << g;
        localparam int N = 16 / B;
        bit seen = 1'b0;

        aes_inv_subbytes #(.BYTES_PER_CYCLE(B)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .dataIn    (data_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .dataOut   (data_out[g]),
            .busy      (busy[g])
        );

        // Monitor: first sight of out_valid checks latency, a handshake pops and checks data.
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid[g]) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb[g].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out_l%0d: got dataOut=%h with nothing pending", g, data_out[g]);
                    end else begin
                        check($sformatf("latency_l%0d", g), 128'(cyc - sb[g][0].acc), 128'(N));
                    end
                end
                if (out_ready[g]) begin
                    if (sb[g].size() != 0) begin
                        e = sb[g].pop_front();
                        check($sformatf("data_l%0d", g), data_out[g], e.data);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    // Reference: forward S-box from GF(2^8) inversion plus affine map, then inverted.
    task automatic build_model();
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h01;
            repeat (254) b = gmul(b, 8'(x));
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] e;
        for (int i = 0; i < 16; i++) e[8*i +: 8] = inv_tab[d[8*i +: 8]];
        return e;
    endfunction

    // Called and returning at posedge+1; returns right after the accepting edge.
    task automatic send(input int l, input logic [127:0] d, input logic [127:0] e, input bit push);
        int waited = 0;
        while (!in_ready[l] && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready[l]) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout_l%0d: in_ready got 0, expected 1", l);
            return;
        end
        in_valid[l] = 1'b1;
        data_in[l]  = d;
        @(posedge clk); #1;
        if (push) sb[l].push_back('{data: e, acc: cyc});
        in_valid[l] = 1'b0;
        data_in[l]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain(input int l);
        int waited = 0;
        while (sb[l].size() != 0 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        check($sformatf("drain_l%0d", l), 128'(sb[l].size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic sweep_lane(input int l);
        logic [127:0] d;
        for (int s = 0; s < 256; s++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(s + i);
            send(l, d, model(d), 1'b1);
        end
        drain(l);
    endtask

    task automatic stream_lane(input int l);
        logic [127:0] d;
        bit done = 1'b0;
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    d = {$urandom, $urandom, $urandom, $urandom};
                    send(l, d, model(d), 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready[l] = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready[l] = 1'b1;
            end
        join
        drain(l);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_model();
        for (int l = 0; l < NI; l++) begin
            in_valid[l]  = 1'b0;
            out_ready[l] = 1'b1;
            data_in[l]   = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < NI; l++) begin
            check($sformatf("rst_in_ready_l%0d", l), in_ready[l], 1);
            check($sformatf("rst_out_valid_l%0d", l), out_valid[l], 0);
            check($sformatf("rst_busy_l%0d", l), busy[l], 0);
            check($sformatf("rst_dataout_l%0d", l), data_out[l], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors on the B=4 instance.
        send(0, 128'h0, {16{8'h52}}, 1'b1);
        check("sub_busy", busy[0], 1);
        check("sub_in_ready", in_ready[0], 0);
        drain(0);
        send(0, {16{8'h63}}, 128'h0, 1'b1);
        send(0, {16{8'hff}}, {16{8'h7d}}, 1'b1);
        send(0, {16{8'h01}}, {16{8'h09}}, 1'b1);
        send(0, 128'h0f0e0d0c0b0a09080706050403020100,
                128'hfbd7f3819ea340bf38a53630d56a0952, 1'b1);
        drain(0);

        // Back-pressure: result must hold for 10 cycles while new inputs are refused.
        out_ready[0] = 1'b0;
        send(0, {16{8'hff}}, {16{8'h7d}}, 1'b1);
        for (int k = 0; k < 50 && !out_valid[0]; k++) begin
            @(posedge clk); #1;
        end
        repeat (10) begin
            in_valid[0] = 1'b1;
            data_in[0]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            in_valid[0] = 1'b0;
            check("hold_out_valid", out_valid[0], 1);
            check("hold_dataout", data_out[0], {16{8'h7d}});
            check("hold_in_ready", in_ready[0], 0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", out_valid[0], 0);
        check("release_in_ready", in_ready[0], 1);
        drain(0);

        // Reset during SUB cycle 2 abandons the state without an output.
        send(0, {16{8'h3c}}, 128'h0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", busy[0], 0);
        check("midrst_in_ready", in_ready[0], 1);
        check("midrst_dataout", data_out[0], 0);
        repeat (8) begin
            check("midrst_no_out_valid", out_valid[0], 0);
            @(posedge clk); #1;
        end
        send(0, 128'h0, {16{8'h52}}, 1'b1);
        drain(0);

        // Every byte value through every lane, all three widths in parallel.
        fork
            sweep_lane(0);
            sweep_lane(1);
            sweep_lane(2);
        join

        // Random back-to-back streams with random downstream readiness.
        fork
            stream_lane(0);
            stream_lane(1);
            stream_lane(2);
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
